// File: rtl/ps2_pkg.sv
// Shared frame constants and the frame-check result type for the PS/2 receiver.
package ps2_pkg;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [1:0] {OK, PAR_ERR, FRM_ERR} chk_t;

  // Frame is stored LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  // Framing errors outrank parity errors.
  function automatic chk_t frame_check(input logic [FRAME_BITS-1:0] f);
    if (f[0] != START_BIT || f[FRAME_BITS-1] != STOP_BIT) return FRM_ERR;
    if (^f[FRAME_BITS-2:1] != 1'b1) return PAR_ERR;
    return OK;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Scan-code FIFO: power-of-two depth, no overwrite when full,
// and a push alongside a pop is accepted even when full.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          wr_en, rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rp];

  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= wdata;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronise and de-glitch the bus, deserialise 11-bit frames,
// check them and queue good scan codes; sticky flags record dropped frames.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   nextdata_n,
  input  logic                   err_clr,
  output logic [7:0]             data,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]            ck_s, dt_s;
  logic                  filt_clk, filt_flip, strobe;
  logic [FW-1:0]         filt_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  frame_done, timeout_abort, push, pop_acc, full, empty;
  chk_t                  chk;

  // Synchronisers and filter idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ck_s     <= 2'b11;
      dt_s     <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
      if (ck_s[1] == filt_clk) filt_cnt <= '0;
      else if (filt_flip) begin
        filt_clk <= ck_s[1];
        filt_cnt <= '0;
      end else filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign filt_flip = (ck_s[1] != filt_clk) && (filt_cnt == FW'(FILTER - 1));
  assign strobe    = filt_flip && filt_clk;
  assign timeout_abort = !strobe && (bit_cnt != '0) && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      sr         <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (strobe) begin
        sr     <= {dt_s[1], sr[FRAME_BITS-1:1]};
        to_cnt <= '0;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else bit_cnt <= bit_cnt + 1'b1;
      end else if (timeout_abort) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (bit_cnt != '0) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
    end
  end

  assign chk     = frame_check(sr);
  assign push    = frame_done && (chk == OK);
  assign pop_acc = !nextdata_n && ready;
  assign ready   = !empty;

  // Clear first so a set event in the same cycle wins.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if ((frame_done && chk == FRM_ERR) || timeout_abort) frame_err <= 1'b1;
      if (frame_done && chk == PAR_ERR) parity_err <= 1'b1;
      if (push && full && !pop_acc) overflow <= 1'b1;
    end
  end

  ps2_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (sr[8:1]),
    .pop   (pop_acc),
    .rdata (data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames; a monitor checks every popped code
// against a queue of expected codes filled by the stimulus.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 100;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       clrn, ps2_clk, ps2_data, nextdata_n, err_clr;
  logic [7:0] data;
  logic       ready, overflow, parity_err, frame_err;
  logic [$clog2(DEPTH):0] level;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .err_clr    (err_clr),
    .data       (data),
    .ready      (ready),
    .level      (level),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected code.
  always @(negedge clk) begin
    if (!clrn && ready && !nextdata_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected none", data);
      end else begin
        chk("pop_data", data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    wait_cycles(1);
    nextdata_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    wait_cycles(1);
  endtask

  // Drive nbits of a frame; glitch adds 2-cycle pulses in both clock phases;
  // pop_end pops for one cycle aligned with the push of the finished frame.
  task automatic send_frame(input logic [7:0] code, input bit bad_par = 0,
                            input bit bad_stop = 0, input int nbits = 11,
                            input bit glitch = 0, input bit pop_end = 0);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        wait_cycles(6); ps2_clk = 1'b0; wait_cycles(2); ps2_clk = 1'b1; wait_cycles(2);
      end else wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (pop_end && i == nbits - 1) begin
        wait_cycles(6); nextdata_n = 1'b0; wait_cycles(1); nextdata_n = 1'b1; wait_cycles(HALF - 7);
      end else if (glitch) begin
        wait_cycles(6); ps2_clk = 1'b1; wait_cycles(2); ps2_clk = 1'b0; wait_cycles(2);
      end else wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] codes2[9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h5A};

  initial begin
    clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; err_clr = 1'b0;
    wait_cycles(3);
    clrn = 1'b0;
    wait_cycles(2);
    chk("rst_ready", ready, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {overflow, parity_err, frame_err}, 0);

    pop_one();
    chk("empty_pop_level", level, 0);

    exp_q.push_back(8'h1C);
    send_frame(8'h1C);
    chk("basic_ready", ready, 1);
    chk("basic_level", level, 1);
    chk("basic_head", data, 8'h1C);
    pop_one();
    chk("basic_level_after", level, 0);
    chk("basic_flags", {overflow, parity_err, frame_err}, 0);

    send_frame(8'h1C, 1);
    chk("par_flag", parity_err, 1);
    chk("par_level", level, 0);
    chk("par_no_frm", frame_err, 0);
    clr_err();
    chk("par_cleared", parity_err, 0);

    send_frame(8'hA5, 0, 1);
    chk("stop_frm", frame_err, 1);
    chk("stop_no_par", parity_err, 0);
    chk("stop_level", level, 0);
    clr_err();

    send_frame(8'h77, 0, 0, 5);
    wait_cycles(TIMEOUT + 2);
    chk("to_frm", frame_err, 1);
    chk("to_level", level, 0);
    exp_q.push_back(8'h32);
    send_frame(8'h32);
    chk("to_next_level", level, 1);
    chk("to_next_head", data, 8'h32);
    pop_one();
    clr_err();

    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 0, 0, 11, 1);
    chk("glitch_level", level, 1);
    chk("glitch_flags", {overflow, parity_err, frame_err}, 0);
    pop_one();

    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back(codes[i]);
      send_frame(codes[i]);
    end
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < DEPTH; i++) pop_one();
    chk("ovf_drained", level, 0);
    clr_err();
    chk("ovf_cleared", overflow, 0);

    for (int i = 0; i < 9; i++) exp_q.push_back(codes2[i]);
    for (int i = 0; i < DEPTH; i++) send_frame(codes2[i]);
    chk("full_level", level, DEPTH);
    send_frame(codes2[8], 0, 0, 11, 0, 1);
    chk("pushpop_level", level, DEPTH);
    chk("pushpop_no_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) pop_one();
    chk("pushpop_drained", level, 0);

    send_frame(8'h11);
    send_frame(8'h22, 0, 0, 5);
    clrn = 1'b1;
    wait_cycles(2);
    clrn = 1'b0;
    wait_cycles(2);
    chk("midrst_level", level, 0);
    chk("midrst_ready", ready, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55);
    chk("midrst_next_level", level, 1);
    chk("midrst_no_frm", frame_err, 0);
    pop_one();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
